// File: rtl/proc_pkg.sv
// Processor-wide constants shared by datapath blocks; callers pick the
// reset-vector or NOP word as the flush value of their pipeline registers.
package proc_pkg;

   localparam int WORD_W = 32;

   localparam logic [WORD_W-1:0] RESET_VECTOR = 32'h0000_0000;
   localparam logic [WORD_W-1:0] NOP_INSN     = 32'h0000_0013;

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle between the hazard/stall logic, the producing stage and
// a pipe_stage_chain; the chain itself uses the slave view.
interface pipe_stage_chain_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic             stall;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] d;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] q;
   logic [OCC_W-1:0] occupancy;

   modport master (
      output stall, flush, in_valid, d,
      input  in_ready, out_valid, q, occupancy
   );

   modport slave (
      input  stall, flush, in_valid, d,
      output in_ready, out_valid, q, occupancy
   );

endinterface

// File: rtl/pipe_stage.sv
// One valid+data register of the chain: clear wins over load, otherwise
// the stage holds.
module pipe_stage #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] INITVALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic             vld_in,
   input  logic [WIDTH-1:0] dat_in,
   output logic             vld,
   output logic [WIDTH-1:0] dat
);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         vld <= 1'b0;
         dat <= INITVALUE;
      end else if (load) begin
         vld <= vld_in;
         dat <= dat_in;
      end
   end

endmodule

// File: rtl/pipe_stage_chain.sv
// Bubble-collapsing pipeline register chain: words keep moving toward the
// output while it is stalled, so every empty slot can absorb a new word.
module pipe_stage_chain
   import proc_pkg::*;
#(
   parameter int               WIDTH     = WORD_W,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] INITVALUE = WIDTH'(RESET_VECTOR)
) (
   input logic                clk,
   input logic                reset,
   pipe_stage_chain_if.slave  bus
);

   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] adv;
   logic [DEPTH-1:0] free;
   logic [DEPTH-1:0] vld_in;
   logic [DEPTH-1:0] vld_next;
   logic [WIDTH-1:0] dat    [DEPTH];
   logic [WIDTH-1:0] dat_in [DEPTH];
   logic [OCC_W-1:0] occ_q;
   logic             run;

   function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [OCC_W-1:0] n;
      n = '0;
      for (int i = 0; i < DEPTH; i++) n = n + OCC_W'(v[i]);
      return n;
   endfunction

   // A stage advances when any stage in front of it is empty or the output
   // itself is draining; accumulating that OR from the output backward keeps
   // the chain free of bit-to-bit self references.
   always_comb begin
      adv = '0;
      run = !bus.stall;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         adv[k] = run;
         if (k > 0) run = run || !vld[k];
      end
      free = ~vld | adv;
   end

   always_comb begin
      vld_in    = vld << 1;
      vld_in[0] = bus.in_valid && free[0];
      dat_in[0] = bus.d;
      for (int k = 1; k < DEPTH; k++) dat_in[k] = dat[k-1];
      vld_next  = (free & vld_in) | (~free & vld);
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      pipe_stage #(
         .WIDTH     (WIDTH),
         .INITVALUE (INITVALUE)
      ) u_stage (
         .clk    (clk),
         .reset  (reset),
         .clear  (bus.flush),
         .load   (free[k]),
         .vld_in (vld_in[k]),
         .dat_in (dat_in[k]),
         .vld    (vld[k]),
         .dat    (dat[k])
      );
   end

   // Occupancy is registered alongside the valid bits rather than decoded
   // from them, so it carries no combinational path to the caller.
   always_ff @(posedge clk) begin
      if (reset || bus.flush) begin
         occ_q <= '0;
      end else begin
         occ_q <= popcount(vld_next);
      end
   end

   assign bus.in_ready  = free[0];
   assign bus.out_valid = vld[DEPTH-1];
   assign bus.q         = dat[DEPTH-1];
   assign bus.occupancy = occ_q;

endmodule
